tdm_mux_8x1: RTL and testbench
==============================

# tdm_mux_8x1

Time-division multiplexer that carries N parallel channels over one serial lane, paired with the team's demultiplexers at the far end. A parallel word is accepted through a valid/ready handshake and replayed one channel per clock. Each output carries the slot select `S` and a `frame` marker, so a downstream 1xN demux can route every sample back to its channel. Frames can run back-to-back with no gap, and the lane can be paused with `hold`.

## Interface
Parameters:
- `N`, 8: number of channels; a power of two and at least 2.
- `W`, 1: bits per channel.
- `SEL_W`, $clog2(N): width of the slot select.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `D`, input, N*W: parallel word; channel i is `D[i*W +: W]`.
- `load_valid`, input, 1: `D` holds a word to send.
- `load_ready`, output, 1: combinational; the block will capture `D` at this edge.
- `hold`, input, 1: pauses the lane; all state and outputs freeze.
- `Y`, output, W: registered serial sample for the current slot.
- `S`, output, SEL_W: registered slot index; drives the demux select.
- `Y_valid`, output, 1: registered; `Y` and `S` are meaningful.
- `frame`, output, 1: registered; high exactly when slot 0 is presented.

## Operation
- Two states:
  - IDLE: no frame in progress.
  - SEND: a frame is being replayed from a shadow register `shadow[N*W-1:0]`, with slot counter `slot` of width SEL_W.
- `load_ready = !rst && !hold && (state==IDLE || (state==SEND && slot==N-1))`.
- Accept means `load_valid && load_ready` at a rising edge. On accept:
  - `shadow <= D`, `slot <= 0`, state becomes SEND.
  - `Y <= D[0 +: W]`, `S <= 0`, `Y_valid <= 1`, `frame <= 1`.
- In SEND, with `hold=0` and `slot<N-1`:
  - `slot` increments.
  - `Y <= shadow[(slot+1)*W +: W]`, `S <= slot+1`, `frame <= 0`, `Y_valid` stays 1.
- In SEND at `slot==N-1`, with `hold=0`:
  - If accept: start the next frame as above, with no idle cycle between frames.
  - Otherwise: go to IDLE with `Y_valid <= 0`, `frame <= 0`. `Y` and `S` keep their last values (don't-care while `Y_valid=0`).
- In IDLE without accept: outputs unchanged, with `Y_valid=0`.
- `hold=1` in any state:
  - No state, counter, shadow or output changes.
  - `load_ready=0`, so no accept can occur and `D` is ignored.
- `slot` wraps only through an accept or through IDLE; it never exceeds N-1.
- Changes on `D` after an accept do not affect the frame in flight.

## Timing
- Reset, applied at any edge including mid-frame: state IDLE, `slot=0`, `shadow=0`, `Y=0`, `S=0`, `Y_valid=0`, `frame=0`. `load_ready` is 0 while `rst` is high.
  - A frame interrupted by reset is dropped and is not resumed.
- First cycle after reset release with `hold=0`: `load_ready=1`.
- Latency: slot 0 appears on `Y`/`S` in the cycle after the accepting edge. Slot i appears i+1 cycles after accept, in the absence of `hold`.
- Throughput: one word per N cycles when `load_valid` is held high, with `frame` pulsing every N cycles.
- Each cycle of `hold` extends the current slot by one cycle; `Y_valid` stays at its pre-hold value.
- `load_valid` may be asserted at any time. It is only sampled when `load_ready=1`, and dropping it when `load_ready=0` is legal.
- `rst` and `load_valid` high together: reset wins and nothing is accepted.

## Test plan
- Reset mid-frame: accept `D=8'hFF`, assert `rst` at slot 3 → next cycle `Y=0`, `S=0`, `Y_valid=0`, `frame=0`; after release `load_ready=1`.
- Single frame (N=8, W=1): `D=8'b1011_0010`, one-cycle valid → over 8 cycles `Y` = 0,1,0,0,1,1,0,1 and `S` = 0..7; `frame` high only with `S=0`; `Y_valid` falls the cycle after `S=7`.
- Back-to-back: `load_valid` held high with `8'hA5` then `8'h3C` → `load_ready` high only at `S=7`; second frame's `S=0`/`frame=1` immediately follows `S=7`, with no bubble in `Y_valid`.
- Hold: assert `hold` for 3 cycles while `S=4` → `S=4` and `Y` persist for 4 cycles total; `load_ready=0` throughout; the sequence then resumes at `S=5`.
- Data stability: change `D` every cycle after accepting `8'hC3` → output sequence still 1,1,0,0,0,0,1,1.
- Parameter sweep: N=4, W=4, `D=16'h4321` → `Y` = 1,2,3,4 with `S` = 0..3.

Source files
------------

// File: rtl/tdm_mux_8x1.sv
// Time-division multiplexer: captures an N-channel parallel word and replays it
// one channel per clock with slot select and frame marker for the far-end demux.
module tdm_mux_8x1 #(
  parameter int N     = 8,
  parameter int W     = 1,
  parameter int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*W-1:0]   D,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             hold,
  output logic [W-1:0]     Y,
  output logic [SEL_W-1:0] S,
  output logic             Y_valid,
  output logic             frame
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state, state_nx;
  logic [SEL_W-1:0]   slot, slot_nx, slot_inc;
  logic [N*W-1:0]     shadow, shadow_nx;
  logic [N-1:0][W-1:0] lanes;
  logic [W-1:0]       y_nx;
  logic [SEL_W-1:0]   s_nx;
  logic               vld_nx, frame_nx;
  logic               last, accept;

  // Channel view of the shadow word; lane i is shadow[i*W +: W].
  assign lanes    = shadow;
  assign last     = (slot == SEL_W'(N-1));
  assign slot_inc = slot + SEL_W'(1);

  assign load_ready = !rst && !hold && (state == IDLE || (state == SEND && last));
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_nx  = state;
    slot_nx   = slot;
    shadow_nx = shadow;
    y_nx      = Y;
    s_nx      = S;
    vld_nx    = Y_valid;
    frame_nx  = frame;
    if (accept) begin
      // Covers both the idle start and the gapless hand-off at the last slot.
      state_nx  = SEND;
      slot_nx   = '0;
      shadow_nx = D;
      y_nx      = D[W-1:0];
      s_nx      = '0;
      vld_nx    = 1'b1;
      frame_nx  = 1'b1;
    end else if (!hold && state == SEND) begin
      if (!last) begin
        slot_nx  = slot_inc;
        y_nx     = lanes[slot_inc];
        s_nx     = slot_inc;
        frame_nx = 1'b0;
      end else begin
        state_nx = IDLE;
        vld_nx   = 1'b0;
        frame_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      slot    <= '0;
      shadow  <= '0;
      Y       <= '0;
      S       <= '0;
      Y_valid <= 1'b0;
      frame   <= 1'b0;
    end else begin
      state   <= state_nx;
      slot    <= slot_nx;
      shadow  <= shadow_nx;
      Y       <= y_nx;
      S       <= s_nx;
      Y_valid <= vld_nx;
      frame   <= frame_nx;
    end
  end

endmodule

// File: tb/tb_tdm_mux_8x1.sv
// Bench for tdm_mux_8x1: queue-based sample model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_tdm_mux_8x1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] D = '0;
  logic       load_valid = 1'b0, hold = 1'b0;
  logic       load_ready, Y, Y_valid, frame;
  logic [2:0] S;

  // Second instance for the N=4, W=4 sweep.
  logic [15:0] D4 = '0;
  logic        lv4 = 1'b0, hold4 = 1'b0;
  logic        lr4, yv4, fr4;
  logic [3:0]  Y4;
  logic [1:0]  S4;

  always #5 clk = ~clk;

  tdm_mux_8x1 dut (
    .clk(clk), .rst(rst), .D(D), .load_valid(load_valid), .load_ready(load_ready),
    .hold(hold), .Y(Y), .S(S), .Y_valid(Y_valid), .frame(frame)
  );

  tdm_mux_8x1 #(.N(4), .W(4)) dut4 (
    .clk(clk), .rst(rst), .D(D4), .load_valid(lv4), .load_ready(lr4),
    .hold(hold4), .Y(Y4), .S(S4), .Y_valid(yv4), .frame(fr4)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: the samples still to be shown are a queue; the displayed sample is
  // the last one popped. A new word is taken only when nothing is pending.
  typedef struct {logic y; int s;} samp_t;
  samp_t q[$];
  logic  my = 1'b0, mv = 1'b0, mf = 1'b0;
  int    ms = 0;
  bit    started = 1'b0;

  always @(posedge clk) begin
    samp_t e;
    if (rst) begin
      q.delete();
      my = 1'b0; ms = 0; mv = 1'b0; mf = 1'b0;
      started = 1'b1;
    end else if (!hold) begin
      if (load_valid && q.size() == 0)
        for (int i = 0; i < 8; i++) q.push_back('{D[i], i});
      if (q.size() > 0) begin
        e = q.pop_front();
        my = e.y; ms = e.s; mv = 1'b1; mf = (e.s == 0);
      end else begin
        mv = 1'b0; mf = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("Y", 32'(Y), 32'(my));
      chk("S", 32'(S), 32'(ms));
      chk("Y_valid", 32'(Y_valid), 32'(mv));
      chk("frame", 32'(frame), 32'(mf));
      chk("load_ready", 32'(load_ready), 32'(!rst && !hold && q.size() == 0));
    end
  end

  logic [7:0]  pat;
  logic [15:0] pat16;
  logic        ysave;

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_Y_valid", 32'(Y_valid), 0);
    chk("rst_ready_low", 32'(load_ready), 0);
    rst = 1'b0; #1;
    chk("post_rst_ready", 32'(load_ready), 1);

    // Single frame
    pat = 8'b1011_0010;
    D = pat; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("single_Y", 32'(Y), 32'(pat[i]));
      chk("single_S", 32'(S), 32'(i));
      chk("single_frame", 32'(frame), 32'(i == 0));
      tick();
    end
    chk("single_valid_fall", 32'(Y_valid), 0);

    // Reset mid-frame
    D = 8'hFF; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick(); tick(); tick();
    chk("mid_S3", 32'(S), 3);
    rst = 1'b1;
    tick();
    chk("midrst_Y", 32'(Y), 0);
    chk("midrst_S", 32'(S), 0);
    chk("midrst_valid", 32'(Y_valid), 0);
    chk("midrst_frame", 32'(frame), 0);
    rst = 1'b0; #1;
    chk("midrst_ready", 32'(load_ready), 1);
    tick(); tick();
    chk("midrst_not_resumed", 32'(Y_valid), 0);

    // Back-to-back frames
    D = 8'hA5; load_valid = 1'b1;
    tick();
    D = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_ready", 32'(load_ready), 32'(i == 7));
      if (i < 7) tick();
    end
    tick();
    load_valid = 1'b0;
    chk("b2b_S0", 32'(S), 0);
    chk("b2b_frame", 32'(frame), 1);
    chk("b2b_valid", 32'(Y_valid), 1);
    chk("b2b_Y", 32'(Y), 0);
    repeat (9) tick();

    // Hold at slot 4
    pat = 8'h5A;
    D = pat; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (4) tick();
    chk("hold_S4", 32'(S), 4);
    ysave = Y;
    chk("hold_Y4", 32'(Y), 32'(pat[4]));
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_ready", 32'(load_ready), 0);
      tick();
      chk("hold_S", 32'(S), 4);
      chk("hold_Y", 32'(Y), 32'(ysave));
      chk("hold_valid", 32'(Y_valid), 1);
    end
    hold = 1'b0;
    tick();
    chk("hold_resume_S", 32'(S), 5);
    chk("hold_resume_Y", 32'(Y), 32'(pat[5]));
    repeat (4) tick();

    // Data stability after accept
    pat = 8'b1100_0011;
    D = 8'hC3; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("stable_Y", 32'(Y), 32'(pat[i]));
      D = 8'($urandom);
      tick();
    end

    // Reset and load_valid together
    rst = 1'b1; load_valid = 1'b1; D = 8'hFF;
    tick();
    rst = 1'b0; load_valid = 1'b0;
    chk("rst_wins_valid", 32'(Y_valid), 0);
    tick();
    chk("rst_wins_idle", 32'(Y_valid), 0);

    // Parameter sweep N=4, W=4
    pat16 = 16'h4321;
    D4 = pat16; lv4 = 1'b1;
    tick();
    lv4 = 1'b0;
    D4 = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      chk("sweep_Y", 32'(Y4), 32'(i + 1));
      chk("sweep_S", 32'(S4), 32'(i));
      chk("sweep_frame", 32'(fr4), 32'(i == 0));
      tick();
    end
    chk("sweep_valid_fall", 32'(yv4), 0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
